// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle. A nonzero divisor gives its result 33 edges after
// acceptance. A zero divisor completes on the next edge with a zero result.
module div #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_W:0]     w_q, w_d;          // {partial remainder, dividend/quotient, spare}
   logic [DATA_W-1:0]     dvs_q, dvs_d;      // divisor magnitude
   logic                  neg1_q, neg1_d;    // signed divide with negative dividend
   logic                  neg2_q, neg2_d;    // signed divide with negative divisor
   logic [2*DATA_W-1:0]   result_d;
   logic                  ready_d;

   logic                  in_neg1, in_neg2;
   logic [DATA_W-1:0]     mag1, mag2;
   logic [DATA_W:0]       diff;
   logic [DATA_W-1:0]     quo, rem;

   // Operand signs and magnitudes at acceptance. 0x80000000 negates to itself.
   // When read as unsigned, that value is 2^31.
   assign in_neg1 = signed_div_i & opdata1_i[DATA_W-1];
   assign in_neg2 = signed_div_i & opdata2_i[DATA_W-1];
   assign mag1    = in_neg1 ? -opdata1_i : opdata1_i;
   assign mag2    = in_neg2 ? -opdata2_i : opdata2_i;

   // Trial subtraction. Bit DATA_W set means the partial remainder is below the divisor.
   assign diff = {1'b0, w_q[2*DATA_W-1:DATA_W]} - {1'b0, dvs_q};

   // Sign fix-up of the final quotient and remainder. Both neg flags already
   // include the signed_div qualifier.
   assign quo = (neg1_q ^ neg2_q) ? -w_q[DATA_W-1:0] : w_q[DATA_W-1:0];
   assign rem = neg1_q ? -w_q[2*DATA_W:DATA_W+1] : w_q[2*DATA_W:DATA_W+1];

   // Next-state and datapath logic; everything holds unless a state says otherwise
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_d      = w_q;
      dvs_d    = dvs_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      result_d = result_o;
      ready_d  = ready_o;
      case (state_q)
         FREE: begin
            if (start_i && !annul_i) begin
               neg1_d = in_neg1;
               neg2_d = in_neg2;
               dvs_d  = mag2;
               if (opdata2_i == '0) begin
                  state_d = BYZERO;
               end else begin
                  state_d = ON;
                  cnt_d   = '0;
                  w_d     = {{DATA_W{1'b0}}, mag1, 1'b0};
               end
            end
         end
         BYZERO: begin
            if (annul_i) begin
               state_d = FREE;
            end else begin
               state_d  = END;
               result_d = '0;
               ready_d  = 1'b1;
            end
         end
         ON: begin
            if (annul_i) begin
               state_d = FREE;
               cnt_d   = '0;
            end else if (cnt_q != CNT_W'(DATA_W)) begin
               if (diff[DATA_W]) w_d = w_q << 1;
               else              w_d = {diff[DATA_W-1:0], w_q[DATA_W-1:0], 1'b1};
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               state_d  = END;
               result_d = {rem, quo};
               ready_d  = 1'b1;
            end
         end
         END: begin
            // Result is held until execute drops start_i; annul has no effect here
            if (!start_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: state_d = FREE;
      endcase
   end

   // State and output registers; async reset discards any in-flight divide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         w_q      <= '0;
         dvs_q    <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         dvs_q    <= dvs_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         result_o <= result_d;
         ready_o  <= ready_d;
      end
   end

endmodule

// File: tb/tb_div.sv
// Directed testbench for div: a table of divides with hand-computed results,
// plus hand-written annul, async-reset and operand-change sequences.
module tb_div;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   int checks = 0;
   int errors = 0;

   div #(.DATA_W(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   // Advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Count edges after acceptance until ready_o, bounded
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready_o && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Full handshake: accept, wait, check latency/result/hold, release
   task automatic run_div(input vec_t v);
      int n;
      signed_div_i = v.sgn;
      opdata1_i    = v.a;
      opdata2_i    = v.b;
      start_i      = 1'b1;
      tick();                      // acceptance edge E0
      wait_ready(n);
      check({v.name, " latency"}, 64'(n), 64'(v.lat));
      check({v.name, " result"}, result_o, v.exp);
      tick();
      tick();
      check({v.name, " hold"}, {63'b0, ready_o} ^ (result_o ^ v.exp), 64'd1);
      start_i = 1'b0;
      tick();
      check({v.name, " release"}, {result_o[62:0], ready_o}, 64'd0);
   endtask

   initial begin
      int n;
      logic seen;

      vecs[0]  = '{"u100/7",        1'b0, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 33};
      vecs[1]  = '{"s-7/2",         1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
      vecs[2]  = '{"s7/-2",         1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
      vecs[3]  = '{"uFFFFFFFF/16",  1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 33};
      vecs[4]  = '{"s-100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33};
      vecs[5]  = '{"uFFFFFFF9/2",   1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33};
      vecs[6]  = '{"u80000000/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33};
      vecs[7]  = '{"s80000000/2",   1'b1, 32'h80000000, 32'h00000002, 64'h00000000_C0000000, 33};
      vecs[8]  = '{"u5/10",         1'b0, 32'h00000005, 32'h0000000A, 64'h00000005_00000000, 33};
      vecs[9]  = '{"umax/1",        1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33};
      vecs[10] = '{"div0",          1'b0, 32'h00001234, 32'h00000000, 64'h0, 1};
      vecs[11] = '{"sdiv0",         1'b1, 32'hFFFFFFFF, 32'h00000000, 64'h0, 1};

      // Reset state
      tick();
      tick();
      check("reset outputs", {result_o[62:0], ready_o}, 64'd0);
      #2 rst = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) run_div(vecs[i]);

      // start with annul is ignored in FREE
      signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
      start_i = 1'b1; annul_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 36; i++) begin tick(); seen |= ready_o; end
      check("start+annul ignored", {63'b0, seen}, 64'd0);
      start_i = 1'b0; annul_i = 1'b0;
      tick();

      // Annul in BYZERO: ready never rises
      opdata1_i = 32'h1234; opdata2_i = 32'h0; start_i = 1'b1;
      tick();                      // E0 -> BYZERO
      annul_i = 1'b1;
      tick();                      // E1 -> FREE
      start_i = 1'b0; annul_i = 1'b0;
      seen = ready_o;
      for (int i = 0; i < 4; i++) begin tick(); seen |= ready_o; end
      check("byzero annul", {63'b0, seen}, 64'd0);

      // Annul at cnt=10, then new divide with start kept high
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      tick();                      // E0
      for (int i = 0; i < 10; i++) tick();
      annul_i = 1'b1; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'h10;
      tick();                      // annul edge -> FREE
      check("annul no ready", {63'b0, ready_o}, 64'd0);
      annul_i = 1'b0;
      tick();                      // re-acceptance
      wait_ready(n);
      check("after annul latency", 64'(n), 64'd33);
      check("after annul result", result_o, 64'h0000000F_0FFFFFFF);
      start_i = 1'b0;
      tick();

      // Async reset mid-divide at cnt=20
      signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) tick();
      #2 rst = 1'b0;
      #1 check("async rst on", {result_o[62:0], ready_o}, 64'd0);
      start_i = 1'b0;
      #2 rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 35; i++) begin tick(); seen |= ready_o; end
      check("no partial survives", {63'b0, seen}, 64'd0);
      run_div('{"s80000000/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33});

      // Async reset while in END clears a held result immediately
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      tick();
      wait_ready(n);
      check("end pre-reset", {result_o[62:0], ready_o}, {63'h00000002_0000000E, 1'b1});
      #2 rst = 1'b0;
      #1 check("async rst end", {result_o[62:0], ready_o}, 64'd0);
      start_i = 1'b0;
      #2 rst = 1'b1;
      tick();

      // Operand change during ON is ignored
      signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      opdata1_i = 32'hDEADBEEF; opdata2_i = 32'h3; signed_div_i = 1'b1;
      wait_ready(n);
      check("op change latency", 64'(n), 64'd28);
      check("op change result", result_o, 64'h00000000_0000000A);
      start_i = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
